block_fall_ctl: RTL and testbench
=================================

BLOCK_FALL_CTL -- requirements
Module: block_fall_ctl

Interface
REQ-001 Parameter FALL_FRAMES, default 30, frames per gravity step in normal mode.
REQ-002 Parameter FAST_FRAMES, default 3, frames per gravity step while btn_down is held.
REQ-003 Parameter SPAWN_COL, default 4, column assigned on spawn.
REQ-004 pclk  in  1  pixel clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 vsync_in  in  1  timing-generator vsync; its rising edge is the frame tick.
REQ-007 start  in  1  synchronous level; leaves IDLE.
REQ-008 btn_left, btn_right, btn_down  in  1 each  raw asynchronous buttons, active-high.
REQ-009 blocked_below  in  1  board occupancy of cell (col, row+1), sampled at the frame tick.
REQ-010 xpos, ypos  out  12 each  registered square top-left pixel, feeds the square-drawing stage.
REQ-011 col  out  4; row  out  5  registered grid position.
REQ-012 landed  out  1  one-pclk pulse when the piece locks.
REQ-013 active  out  1  high in FALL state.

Function
REQ-014 Each button SHALL pass a 2-FF synchronizer; left/right SHALL be rising-edge detected on the synchronized signal.
REQ-015 A detected left/right edge SHALL set a pending flag; flags SHALL be applied only at the next frame tick, then cleared.
REQ-016 Frame tick = registered vsync_in low-to-high transition; exactly one pclk pulse per frame.
REQ-017 States: IDLE, FALL, LOCK; IDLE->FALL when start=1 (col=SPAWN_COL, row=0, frame counter=0).
REQ-018 In FALL, per frame tick: horizontal move first, then gravity; both may apply on the same tick.
REQ-019 Pending left and right both set -> no horizontal move; both flags cleared.
REQ-020 Left at col=0 or right at col=9 -> no move (clamp), flag cleared.
REQ-021 Frame counter increments each tick; gravity step when counter reaches limit-1 (limit = FAST_FRAMES if synchronized btn_down=1 at the tick, else FALL_FRAMES), then counter=0.
REQ-022 Switching between normal and fast mode mid-count SHALL NOT reset the counter; if counter >= new limit-1, the step occurs at that tick.
REQ-023 Gravity step: if row=19 or blocked_below=1 -> go to LOCK, row unchanged; else row=row+1.
REQ-024 LOCK lasts exactly one pclk: landed=1 for that cycle, then respawn (col=SPAWN_COL, row=0, counter=0) and return to FALL.
REQ-025 Pending flags SHALL be cleared on entry to LOCK and ignored in IDLE.
REQ-026 xpos = 201 + 35*col, ypos = 10 + 35*row, zero-extended to 12 bits (max 516/675, no overflow); registered, valid one pclk after col/row update.
REQ-027 active=1 iff state=FALL; col/row/xpos/ypos hold between updates.

Reset
REQ-028 On rst: state=IDLE, col=SPAWN_COL, row=0, xpos=341, ypos=10, landed=0, active=0, counter=0, pending flags and synchronizers=0.
REQ-029 rst asserted mid-fall or during LOCK SHALL abort immediately; no landed pulse generated.
REQ-030 After rst release, block SHALL remain in IDLE until start=1, regardless of vsync or buttons.

Verification
REQ-031 Reset release, start pulse, 30 ticks with no buttons -> row 0->1 on tick 30, xpos=341, ypos=45 one pclk later.
REQ-032 btn_down held, 60 ticks from row 0 -> row=19 after 57 ticks, LOCK and landed pulse on 60th tick, then col=4,row=0.
REQ-033 Five left presses between ticks each at col=4 -> col=0 then clamps; xpos=201; left+right in same frame -> col unchanged.
REQ-034 blocked_below=1 at gravity tick, row=7 -> landed single pulse, row stays 7 that cycle, respawn next cycle.
REQ-035 rst asserted 3 frames into fall -> all outputs at reset values asynchronously, no landed; start required to resume.
REQ-036 btn_down pressed at counter=10 (normal) -> gravity step on that tick, counter=0.

Source files
------------

// File: rtl/block_fall_ctl.sv
// Falling-square controller: synchronizes buttons, derives a frame tick from vsync
// and steps one square across a 10x20 grid with clamped moves, gravity and lock.
module block_fall_ctl #(
  parameter int FALL_FRAMES = 30,
  parameter int FAST_FRAMES = 3,
  parameter int SPAWN_COL   = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        blocked_below,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [3:0]  col,
  output logic [4:0]  row,
  output logic        landed,
  output logic        active,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FALL = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam int CW = $clog2(FALL_FRAMES + FAST_FRAMES + 1);
  localparam logic [3:0]  SPAWN_C = 4'(SPAWN_COL);
  localparam logic [11:0] X_RST   = 12'(201 + 35 * SPAWN_COL);

  // bit 0 = left, bit 1 = right, bit 2 = down
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [1:0] lr_prev_q, lr_prev_d;
  logic       vs1_q, vs1_d;
  logic       vs2_q, vs2_d;

  logic [1:0]    state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pl_q, pl_d;
  logic          pr_q, pr_d;
  logic          landed_q, landed_d;
  logic [11:0]   xpos_q, xpos_d;
  logic [11:0]   ypos_q, ypos_d;

  logic          tick;
  logic          left_edge;
  logic          right_edge;
  logic [CW-1:0] limit_m1;

  always_comb begin
    sync1_d   = {btn_down, btn_right, btn_left};
    sync2_d   = sync1_q;
    lr_prev_d = sync2_q[1:0];
    vs1_d     = vsync_in;
    vs2_d     = vs1_q;
  end

  assign tick       = vs1_q & ~vs2_q;
  assign left_edge  = sync2_q[0] & ~lr_prev_q[0];
  assign right_edge = sync2_q[1] & ~lr_prev_q[1];
  assign limit_m1   = sync2_q[2] ? CW'(FAST_FRAMES - 1) : CW'(FALL_FRAMES - 1);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    pl_d     = pl_q;
    pr_d     = pr_q;
    landed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pl_d = 1'b0;
        pr_d = 1'b0;
        if (start) begin
          state_d = ST_FALL;
          col_d   = SPAWN_C;
          row_d   = 5'd0;
          cnt_d   = '0;
        end
      end
      ST_FALL: begin
        if (left_edge)  pl_d = 1'b1;
        if (right_edge) pr_d = 1'b1;
        if (tick) begin
          // Flags pending before this tick are consumed; an edge landing on
          // the tick cycle itself waits for the following frame.
          if (pl_q && !pr_q && col_q != 4'd0) col_d = col_q - 4'd1;
          if (pr_q && !pl_q && col_q != 4'd9) col_d = col_q + 4'd1;
          pl_d = left_edge;
          pr_d = right_edge;
          if (cnt_q >= limit_m1) begin
            cnt_d = '0;
            if (row_q == 5'd19 || blocked_below) begin
              state_d  = ST_LOCK;
              landed_d = 1'b1;
              pl_d     = 1'b0;
              pr_d     = 1'b0;
            end else begin
              row_d = row_q + 5'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_LOCK: begin
        state_d = ST_FALL;
        col_d   = SPAWN_C;
        row_d   = 5'd0;
        cnt_d   = '0;
        pl_d    = 1'b0;
        pr_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    xpos_d = 12'd201 + 12'd35 * 12'(col_q);
    ypos_d = 12'd10 + 12'd35 * 12'(row_q);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 3'd0;
      sync2_q   <= 3'd0;
      lr_prev_q <= 2'd0;
      vs1_q     <= 1'b0;
      vs2_q     <= 1'b0;
      state_q   <= ST_IDLE;
      col_q     <= SPAWN_C;
      row_q     <= 5'd0;
      cnt_q     <= '0;
      pl_q      <= 1'b0;
      pr_q      <= 1'b0;
      landed_q  <= 1'b0;
      xpos_q    <= X_RST;
      ypos_q    <= 12'd10;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lr_prev_q <= lr_prev_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      pl_q      <= pl_d;
      pr_q      <= pr_d;
      landed_q  <= landed_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign col       = col_q;
  assign row       = row_q;
  assign landed    = landed_q;
  assign active    = (state_q == ST_FALL);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_block_fall_ctl.sv
// Bench for block_fall_ctl: directed scenarios plus a randomized run, all
// checked against a frame-level model of the falling square.
module tb_block_fall_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_in = 1'b0;
  logic        start = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_down = 1'b0;
  logic        blocked_below = 1'b0;
  logic [11:0] xpos, ypos;
  logic [3:0]  col;
  logic [4:0]  row;
  logic        landed, active;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // frame-level reference model
  bit m_fall;
  bit m_pl, m_pr;
  int m_col, m_row, m_cnt;

  block_fall_ctl dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .blocked_below(blocked_below), .xpos(xpos), .ypos(ypos), .col(col),
    .row(row), .landed(landed), .active(active), .state_dbg(state_dbg)
  );

  always #5 pclk = ~pclk;

  task automatic model_reset();
    m_fall = 0; m_pl = 0; m_pr = 0; m_col = 4; m_row = 0; m_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; vsync_in = 0; start = 0;
    btn_left = 0; btn_right = 0; btn_down = 0; blocked_below = 0;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge pclk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    repeat (2) @(negedge pclk);
    if (!m_fall) begin
      m_fall = 1; m_col = 4; m_row = 0; m_cnt = 0; m_pl = 0; m_pr = 0;
    end
  endtask

  task automatic press(input bit l, input bit r);
    btn_left = l; btn_right = r;
    repeat (4) @(negedge pclk);
    btn_left = 0; btn_right = 0;
    repeat (4) @(negedge pclk);
    if (m_fall) begin
      if (l) m_pl = 1;
      if (r) m_pr = 1;
    end
  endtask

  // One vsync frame; updates the model and compares every visible output.
  task automatic do_frame(input bit down, input bit blk);
    int land_cnt, land_row, exp_land, pre_row;
    land_cnt = 0; land_row = -1; exp_land = 0; pre_row = m_row;
    btn_down = down; blocked_below = blk;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) vsync_in = 1'b1;
      if (i == 8) vsync_in = 1'b0;
      @(negedge pclk);
      if (landed === 1'b1) begin land_cnt++; land_row = row; end
    end
    if (m_fall) begin
      if (m_pl && !m_pr && m_col > 0) m_col--;
      else if (m_pr && !m_pl && m_col < 9) m_col++;
      m_pl = 0; m_pr = 0;
      if (m_cnt >= (down ? 3 : 30) - 1) begin
        m_cnt = 0;
        if (m_row == 19 || blk) begin
          exp_land = 1; m_col = 4; m_row = 0;
        end else m_row++;
      end else m_cnt++;
    end
    n_tests++;
    if (land_cnt !== exp_land) begin
      n_fail++; $display("FAIL landed_pulses: got %0d want %0d", land_cnt, exp_land);
    end
    if (exp_land == 1 && land_cnt == 1) begin
      n_tests++;
      if (land_row !== pre_row) begin
        n_fail++; $display("FAIL row_at_lock: got %0d want %0d", land_row, pre_row);
      end
    end
    n_tests++;
    if (col !== 4'(m_col) || row !== 5'(m_row)) begin
      n_fail++; $display("FAIL grid_pos: got col=%0d row=%0d want col=%0d row=%0d", col, row, m_col, m_row);
    end
    n_tests++;
    if (xpos !== 12'(201 + 35 * m_col) || ypos !== 12'(10 + 35 * m_row)) begin
      n_fail++; $display("FAIL pixel_pos: got x=%0d y=%0d want x=%0d y=%0d", xpos, ypos, 201 + 35 * m_col, 10 + 35 * m_row);
    end
    n_tests++;
    if (active !== m_fall) begin
      n_fail++; $display("FAIL active: got %b want %b", active, m_fall);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (state_dbg !== 2'd0 || col !== 4'd4 || row !== 5'd0 || xpos !== 12'd341 ||
        ypos !== 12'd10 || landed !== 1'b0 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got st=%0d col=%0d row=%0d x=%0d y=%0d ld=%b act=%b want 0/4/0/341/10/0/0",
               state_dbg, col, row, xpos, ypos, landed, active);
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    press(1, 0);
    press(0, 1);
    for (int i = 0; i < 4; i++) do_frame(1, 1);
    n_tests++;
    if (state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL idle_hold: got state %0d want 0", state_dbg);
    end
  endtask

  task automatic test_normal_fall();
    do_reset();
    do_start();
    for (int i = 0; i < 29; i++) do_frame(0, 0);
    n_tests++;
    if (row !== 5'd0) begin
      n_fail++; $display("FAIL row_before_tick30: got %0d want 0", row);
    end
    do_frame(0, 0);
    n_tests++;
    if (row !== 5'd1 || xpos !== 12'd341 || ypos !== 12'd45) begin
      n_fail++; $display("FAIL tick30_step: got row=%0d x=%0d y=%0d want 1/341/45", row, xpos, ypos);
    end
  endtask

  task automatic test_fast_to_lock();
    do_reset();
    do_start();
    for (int i = 0; i < 57; i++) do_frame(1, 0);
    n_tests++;
    if (row !== 5'd19) begin
      n_fail++; $display("FAIL fast_row19: got %0d want 19", row);
    end
    for (int i = 0; i < 3; i++) do_frame(1, 0);
    n_tests++;
    if (col !== 4'd4 || row !== 5'd0 || active !== 1'b1) begin
      n_fail++; $display("FAIL respawn: got col=%0d row=%0d act=%b want 4/0/1", col, row, active);
    end
  endtask

  task automatic test_left_clamp();
    do_reset();
    do_start();
    for (int i = 0; i < 5; i++) begin
      press(1, 0);
      do_frame(0, 0);
    end
    n_tests++;
    if (col !== 4'd0 || xpos !== 12'd201) begin
      n_fail++; $display("FAIL left_clamp: got col=%0d x=%0d want 0/201", col, xpos);
    end
    press(0, 1);
    press(1, 0);
    do_frame(0, 0);
    n_tests++;
    if (col !== 4'd0) begin
      n_fail++; $display("FAIL left_right_cancel: got col=%0d want 0", col);
    end
    for (int i = 0; i < 11; i++) begin
      press(0, 1);
      do_frame(0, 0);
    end
    n_tests++;
    if (col !== 4'd9) begin
      n_fail++; $display("FAIL right_clamp: got col=%0d want 9", col);
    end
  endtask

  task automatic test_blocked();
    do_reset();
    do_start();
    for (int i = 0; i < 21; i++) do_frame(1, 0);
    n_tests++;
    if (row !== 5'd7) begin
      n_fail++; $display("FAIL reach_row7: got %0d want 7", row);
    end
    for (int i = 0; i < 3; i++) do_frame(1, 1);
  endtask

  task automatic test_mode_switch();
    do_reset();
    do_start();
    for (int i = 0; i < 10; i++) do_frame(0, 0);
    do_frame(1, 0);
    n_tests++;
    if (row !== 5'd1) begin
      n_fail++; $display("FAIL switch_step: got row=%0d want 1", row);
    end
    do_frame(1, 0);
    do_frame(1, 0);
    n_tests++;
    if (row !== 5'd1) begin
      n_fail++; $display("FAIL counter_cleared: got row=%0d want 1", row);
    end
    do_frame(1, 0);
  endtask

  task automatic test_reset_midfall();
    do_reset();
    do_start();
    press(1, 0);
    for (int i = 0; i < 3; i++) do_frame(1, 0);
    @(posedge pclk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (state_dbg !== 2'd0 || col !== 4'd4 || row !== 5'd0 || xpos !== 12'd341 ||
        ypos !== 12'd10 || landed !== 1'b0 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d col=%0d row=%0d x=%0d y=%0d ld=%b act=%b want 0/4/0/341/10/0/0",
               state_dbg, col, row, xpos, ypos, landed, active);
    end
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) do_frame(1, 0);
    do_start();
    do_frame(1, 0);
  endtask

  task automatic test_random();
    int op;
    do_reset();
    do_start();
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: press(1, 0);
        1: press(0, 1);
        2: press(1, 1);
        default: do_frame(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 7) == 0));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_normal_fall();
    test_fast_to_lock();
    test_left_clamp();
    test_blocked();
    test_mode_switch();
    test_reset_midfall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
